// File: rtl/cpu5_mem_arb_pkg.sv
// ============================================================================
// Module : cpu5_mem_arb_pkg
// Brief  : Shared defines, state encodings and widths for the cpu5 memory
//          arbiter. Optional feature macro: CPU5_MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
`ifndef CPU5_MEM_ARB_STATE_W
`define CPU5_MEM_ARB_STATE_W 2
`define CPU5_MEM_ARB_IDLE    2'd0
`define CPU5_MEM_ARB_BUSY_I  2'd1
`define CPU5_MEM_ARB_BUSY_D  2'd2
`define CPU5_MEM_ARB_STARVE_LIMIT 4
`define CPU5_MEM_ARB_TIMEOUT      64
`endif

package cpu5_mem_arb_pkg;

  typedef enum logic [`CPU5_MEM_ARB_STATE_W-1:0] {
    ST_IDLE   = `CPU5_MEM_ARB_IDLE,
    ST_BUSY_I = `CPU5_MEM_ARB_BUSY_I,
    ST_BUSY_D = `CPU5_MEM_ARB_BUSY_D
  } arb_state_t;

  localparam int C_STARVE_W = 4;
  localparam int C_WDOG_W   = 8;

endpackage

`default_nettype wire

// File: rtl/cpu5_mem_arb_wdog.sv
// ============================================================================
// Module : cpu5_mem_arb_wdog
// Brief  : Per-transaction wait counter; flags expiry after TIMEOUT BUSY
//          cycles without ack. Built only with CPU5_MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu5_mem_arb_wdog
  import cpu5_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = `CPU5_MEM_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam logic [C_WDOG_W-1:0] C_LIMIT = C_WDOG_W'(TIMEOUT - 1);

  logic [C_WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (busy && !ack && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = busy && (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/cpu5_mem_arb.sv
// ============================================================================
// Module : cpu5_mem_arb
// Brief  : Two-port (fetch/data) to one-port memory arbiter, data priority
//          with starvation bound. Optional macro: CPU5_MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu5_mem_arb
  import cpu5_mem_arb_pkg::*;
#(
  parameter int XLEN         = `CPU5_XLEN,
  parameter int STARVE_LIMIT = `CPU5_MEM_ARB_STARVE_LIMIT,
  parameter int TIMEOUT      = `CPU5_MEM_ARB_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack,
  output logic            err
);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("cpu5_mem_arb: STARVE_LIMIT or TIMEOUT out of range");
    end
  endgenerate

  localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_LIMIT);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [C_STARVE_W-1:0] r_starve_cnt;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic                  r_we;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_starved;
  logic                  w_busy;
  logic                  w_expire;
  logic                  w_done;
  logic                  w_abort;

  assign w_starved = (r_starve_cnt == C_STARVE_MAX);
  assign w_busy    = (r_state != ST_IDLE);
  assign w_done    = m_ack | w_expire;
  assign w_abort   = w_expire & ~m_ack;

`ifdef CPU5_MEM_ARB_TIMEOUT_EN
  cpu5_mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .start  (w_grant_i | w_grant_d),
    .busy   (w_busy),
    .ack    (m_ack),
    .expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    err          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_req && !(i_req && w_starved)) begin
          w_grant_d    = 1'b1;
          w_next_state = ST_BUSY_D;
        end else if (i_req) begin
          w_grant_i    = 1'b1;
          w_next_state = ST_BUSY_I;
        end
      end
      ST_BUSY_I: begin
        i_ready = w_done;
        err     = w_abort;
        if (w_done) w_next_state = ST_IDLE;
      end
      ST_BUSY_D: begin
        d_ready = w_done;
        err     = w_abort;
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Counter only moves on grants, so it can never pass STARVE_LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i) begin
        r_starve_cnt <= '0;
        r_addr       <= i_addr;
        r_wdata      <= '0;
        r_we         <= 1'b0;
      end else if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_we    <= d_we;
        if (!i_req) begin
          r_starve_cnt <= '0;
        end else if (!w_starved) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

  assign m_req   = w_busy;
  assign m_we    = (r_state == ST_BUSY_D) & r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign i_rdata = w_abort ? '0 : m_rdata;
  assign d_rdata = w_abort ? '0 : m_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu5_mem_arb.sv
// ============================================================================
// Module : tb_cpu5_mem_arb
// Brief  : Scoreboard bench for cpu5_mem_arb; honours CPU5_MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu5_mem_arb;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic         i_ready, d_ready, m_req, m_we, err;
  logic [W-1:0] m_rdata;
  logic         m_ack;

  cpu5_mem_arb #(.XLEN(W), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         port;   // 1 = data, 0 = fetch
    logic [W-1:0] rdata;
    logic         err;
    logic         chk_rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   mem_lat   = 1;
  bit   mem_never = 1'b0;
  int   wc        = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
  endfunction

  // Memory model: acks the mem_lat-th BUSY cycle of each transaction.
  always @(posedge clk) begin
    #1;
    if (!m_req) begin
      wc      = 0;
      m_ack   = 1'b0;
      m_rdata = 32'hBAD0BAD0;
    end else begin
      if (!mem_never && wc == mem_lat - 1) begin
        m_ack   = 1'b1;
        m_rdata = mem_fn(m_addr);
      end else begin
        m_ack   = 1'b0;
        m_rdata = 32'hBAD0BAD0;
      end
      wc++;
    end
  end

  // Monitor: every completion pops the oldest expected response.
  always @(negedge clk) begin
    if (!reset && (i_ready || d_ready || err)) begin
      exp_t e;
      if (i_ready && d_ready) check("both_ready", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_completion", {31'd0, d_ready}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        check("sb_port", {31'd0, d_ready}, {31'd0, e.port});
        check("sb_ready", {31'd0, (e.port ? d_ready : i_ready)}, 32'd1);
        check("sb_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_rdata) check("sb_rdata", e.port ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "tb_cpu5_mem_arb timeout");
  end

  initial begin
    bit found;
    bit bad;
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;
    step(); step();
    at_neg();
    check("rst_m_req", {31'd0, m_req}, 32'd0);
    check("rst_m_we", {31'd0, m_we}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Fetch only, zero-wait memory
    mem_lat = 1;
    i_req = 1; i_addr = 32'h100;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 1'b1});
    at_neg();
    check("fetch_m_req_lat0", {31'd0, m_req}, 32'd0);
    step(); at_neg();
    check("fetch_m_req", {31'd0, m_req}, 32'd1);
    check("fetch_m_addr", m_addr, 32'h100);
    check("fetch_m_we", {31'd0, m_we}, 32'd0);
    check("fetch_i_ready", {31'd0, i_ready}, 32'd1);
    step();
    i_req = 0;
    at_neg();
    check("fetch_no_regrant", {31'd0, m_req}, 32'd0);
    step();

    // Store with 3-cycle memory latency
    mem_lat = 3;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678;
    sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
    step();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("st_m_req", {31'd0, m_req}, 32'd1);
      check("st_m_we", {31'd0, m_we}, 32'd1);
      check("st_m_addr", m_addr, 32'h2000);
      check("st_m_wdata", m_wdata, 32'h12345678);
      check("st_d_ready", {31'd0, d_ready}, (k == 2) ? 32'd1 : 32'd0);
      check("st_i_ready", {31'd0, i_ready}, 32'd0);
      step();
    end
    d_req = 0; d_we = 0;
    at_neg();
    check("st_idle", {31'd0, m_req}, 32'd0);
    step();

    // Simultaneous requests: data first, one bubble, then fetch
    mem_lat = 1;
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_addr = 32'h400;
    sb.push_back('{1'b1, 32'hA5A50400, 1'b0, 1'b1});
    sb.push_back('{1'b0, 32'hA5A50300, 1'b0, 1'b1});
    step(); at_neg();
    check("sim_d_addr", m_addr, 32'h400);
    check("sim_d_m_req", {31'd0, m_req}, 32'd1);
    step();
    d_req = 0;
    at_neg();
    check("sim_bubble", {31'd0, m_req}, 32'd0);
    step(); at_neg();
    check("sim_i_addr", m_addr, 32'h300);
    check("sim_i_m_req", {31'd0, m_req}, 32'd1);
    step();
    i_req = 0;
    step();

    // Starvation: fetch held, data reissued continuously
    i_req = 1; i_addr = 32'h500;
    d_req = 1; d_addr = 32'h600;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 32'hA5A50600, 1'b0, 1'b1});
    sb.push_back('{1'b0, 32'hA5A50500, 1'b0, 1'b1});
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (c == 7) check("starve_cnt_sat", {28'd0, dut.r_starve_cnt}, 32'd4);
      if (c == 9) check("starve_cnt_clr", {28'd0, dut.r_starve_cnt}, 32'd0);
      step();
    end
    i_req = 0; d_req = 0;
    step();

    // Reset in the 2nd latency cycle of a data access
    mem_lat = 5;
    d_req = 1; d_addr = 32'h700;
    step(); step();
    reset = 1'b1;
    at_neg();
    check("rst_mid_m_req", {31'd0, m_req}, 32'd0);
    check("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
    step();
    reset = 1'b0; d_req = 0;
    step();
    mem_lat = 2;
    i_req = 1; i_addr = 32'h800;
    sb.push_back('{1'b0, 32'hA5A50800, 1'b0, 1'b1});
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      at_neg();
      if (i_ready) found = 1'b1;
      step();
    end
    check("post_rst_fetch_done", {31'd0, found}, 32'd1);
    i_req = 0;
    step();

`ifdef CPU5_MEM_ARB_TIMEOUT_EN
    // Memory never acks: abort after TIMEOUT busy cycles
    mem_never = 1'b1;
    d_req = 1; d_addr = 32'h900;
    sb.push_back('{1'b1, 32'h0, 1'b1, 1'b1});
    for (int c = 1; c <= 8; c++) begin
      step(); at_neg();
      check("to_d_ready", {31'd0, d_ready}, (c == 8) ? 32'd1 : 32'd0);
    end
    step();
    d_req = 0;
    at_neg();
    check("to_idle", {31'd0, m_req}, 32'd0);
    step();
    // Ack in the expiry cycle wins over the abort
    mem_never = 1'b0; mem_lat = 8;
    d_req = 1; d_addr = 32'hA00;
    sb.push_back('{1'b1, 32'hA5A50A00, 1'b0, 1'b1});
    for (int c = 1; c <= 8; c++) step();
    d_req = 0;
    step();
`else
    // Memory never acks: arbiter keeps waiting with no error
    mem_never = 1'b1;
    d_req = 1; d_addr = 32'h900;
    step();
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      at_neg();
      if (m_req !== 1'b1 || err !== 1'b0 || d_ready !== 1'b0) bad = 1'b1;
      step();
    end
    check("no_to_wait", {31'd0, bad}, 32'd0);
    reset = 1'b1; d_req = 0;
    step();
    reset = 1'b0; mem_never = 1'b0;
    step();
`endif

    step(); step();
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
